// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flow-controlled FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AF_MARGIN  = 2;
    localparam int DEF_AE_THRESH  = 2;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]     rdata
);

    // Storage words carry no reset so the array can map onto plain flops or LUT RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fc.sv
// Single-clock FIFO with occupancy count, programmable almost flags and sticky error flags.
module sync_fifo_fc
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_THRESH  = DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    rd_en,
    input  logic                    clr_err,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_acc, rd_acc;

    // Flags decode only the registered count, keeping request inputs off every flag path.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Set term is OR'd last so a fresh error survives a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clr_err) | (wr_en & full);
            underflow <= (underflow & ~clr_err) | (rd_en & empty);
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is gated while empty so dout reads zero out of reset.
            assign dout  = empty ? '0 : rd_data;
            assign valid = ~empty;
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout  <= '0;
                    valid <= 1'b0;
                end else begin
                    valid <= rd_acc;
                    if (rd_acc) dout <= rd_data;
                end
            end
        end
    endgenerate

endmodule
